// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates from a sampled VGA stream and locks onto H_TOTAL x V_TOTAL timing.
// Define VGA_DEC_CHECKSUM_EN to add the per-frame r+g+b checksum outputs (frame_sum, frame_sum_valid).
module vga_timing_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_rgb,
    output logic [10:0] line_len,
    output logic        locked,
    output logic        sync_err
`ifdef VGA_DEC_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum,
    output logic        frame_sum_valid
`endif
);
    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [10:0] hcount_q, hcount_d, line_len_q, line_len_d;
    logic [9:0]  vcount_q, vcount_d, x_q, x_d, y_q, y_d;
    logic        line_act_q, line_act_d, first_line_q, first_line_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  good_q, good_d, good_inc;
    logic        locked_q, locked_d, sync_err_q, sync_err_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;

    logic        hs_fall, vs_fall, h_fail, v_fail, capture;
    logic [10:0] hcount_inc;
    logic [9:0]  vcount_line, x_cur, y_cur;

    assign hs_fall     = pix_en & hs_prev_q & ~hsync;
    assign vs_fall     = pix_en & vs_prev_q & ~vsync;
    assign hcount_inc  = (hcount_q == 11'h7FF) ? hcount_q : hcount_q + 11'd1;
    // The line ending on this sample is counted before any vertical check.
    assign vcount_line = (hs_fall && vcount_q != 10'h3FF) ? vcount_q + 10'd1 : vcount_q;
    assign x_cur       = hs_fall ? 10'd0 : x_q;
    assign y_cur       = vs_fall ? 10'd0 :
                         ((hs_fall && line_act_q && y_q != 10'h3FF) ? y_q + 10'd1 : y_q);
    assign h_fail      = (state_q != ST_SEARCH) && hs_fall && !first_line_q
                         && (32'(hcount_inc) != H_TOTAL);
    assign v_fail      = (state_q != ST_SEARCH) && vs_fall && (32'(vcount_line) != V_TOTAL);
    assign capture     = pix_en && blank && (state_q == ST_LOCKED);
    assign good_inc    = good_q + 8'd1;

    always_comb begin
        hs_prev_d    = hs_prev_q;
        vs_prev_d    = vs_prev_q;
        hcount_d     = hcount_q;
        line_len_d   = line_len_q;
        vcount_d     = vcount_q;
        x_d          = x_q;
        y_d          = y_q;
        line_act_d   = line_act_q;
        first_line_d = first_line_q;
        state_d      = state_q;
        good_d       = good_q;
        locked_d     = locked_q;
        sync_err_d   = 1'b0;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        if (pix_en) begin
            hs_prev_d  = hsync;
            vs_prev_d  = vsync;
            hcount_d   = hs_fall ? 11'd0 : hcount_inc;
            if (hs_fall) begin
                line_len_d = hcount_inc;
            end
            vcount_d   = vs_fall ? 10'd0 : vcount_line;
            x_d        = (blank && x_cur != 10'h3FF) ? x_cur + 10'd1 : x_cur;
            y_d        = y_cur;
            line_act_d = (hs_fall ? 1'b0 : line_act_q) | blank;
            if (capture) begin
                pix_valid_d = 1'b1;
                pix_x_d     = x_cur;
                pix_y_d     = y_cur;
                pix_rgb_d   = {r, g, b};
            end
            if (state_q == ST_SEARCH) begin
                if (vs_fall) begin
                    state_d      = ST_MEASURE;
                    good_d       = 8'd0;
                    first_line_d = 1'b1;
                end
            end else begin
                if (hs_fall) begin
                    first_line_d = 1'b0;
                end
                if (h_fail || v_fail) begin
                    sync_err_d = 1'b1;
                    good_d     = 8'd0;
                    locked_d   = 1'b0;
                    state_d    = ST_SEARCH;
                end else if (vs_fall && state_q == ST_MEASURE) begin
                    good_d = good_inc;
                    if (32'(good_inc) == LOCK_FRAMES) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            hcount_q     <= '0;
            line_len_q   <= '0;
            vcount_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            line_act_q   <= 1'b0;
            first_line_q <= 1'b0;
            state_q      <= ST_SEARCH;
            good_q       <= '0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_rgb_q    <= '0;
        end else begin
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hcount_q     <= hcount_d;
            line_len_q   <= line_len_d;
            vcount_q     <= vcount_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_act_q   <= line_act_d;
            first_line_q <= first_line_d;
            state_q      <= state_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_rgb   = pix_rgb_q;
    assign line_len  = line_len_q;
    assign locked    = locked_q;
    assign sync_err  = sync_err_q;

`ifdef VGA_DEC_CHECKSUM_EN
    logic [15:0] acc_q, acc_d, acc_base, frame_sum_q, frame_sum_d, rgb_sum;
    logic        frame_sum_valid_q, frame_sum_valid_d;

    assign rgb_sum = 16'(r) + 16'(g) + 16'(b);

    // Accumulator only runs while locked; a pixel on the presenting sample starts the new frame.
    always_comb begin
        acc_d             = acc_q;
        acc_base          = acc_q;
        frame_sum_d       = frame_sum_q;
        frame_sum_valid_d = 1'b0;
        if (pix_en) begin
            if (state_q != ST_LOCKED) begin
                acc_d = '0;
            end else begin
                if (vs_fall) begin
                    frame_sum_d       = acc_q;
                    frame_sum_valid_d = 1'b1;
                    acc_base          = '0;
                end
                acc_d = acc_base + (blank ? rgb_sum : 16'd0);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q             <= '0;
            frame_sum_q       <= '0;
            frame_sum_valid_q <= 1'b0;
        end else begin
            acc_q             <= acc_d;
            frame_sum_q       <= frame_sum_d;
            frame_sum_valid_q <= frame_sum_valid_d;
        end
    end

    assign frame_sum       = frame_sum_q;
    assign frame_sum_valid = frame_sum_valid_q;
`endif

endmodule
